// File: rtl/apb_master_nslave.sv
// APB requester fanning one request port out to NUM_SLV completers chosen by the top address bits.
// Optional wait-state abort is compiled in when APB_TIMEOUT_EN is defined.
module apb_master_nslave #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      transfer,
  input  logic                      READ_WRITE,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nxt;
  logic                accept, done, dec_err, tmo;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  // Out-of-range indices shift the single set bit off the top, leaving an all-zero select.
  function automatic logic [NUM_SLV-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W-1:0] idx;
    idx    = addr[ADDR_W-1 -: SEL_W];
    decode = {{(NUM_SLV-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Only the selected completer's ready/error/data can reach the response path.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)              wait_cnt <= '0;
    else if (state != ACCESS)  wait_cnt <= '0;
    else if (!sel_ready)       wait_cnt <= wait_cnt + 8'd1;
  end

  // Fires on the TIMEOUT_CYC-th consecutive wait-state cycle.
  assign tmo = (state == ACCESS) && !sel_ready && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    dec_err   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (transfer) state_nxt = SETUP;
      end
      SETUP: begin
        if (PSEL == '0) begin
          dec_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (sel_ready || tmo) begin
          done      = 1'b1;
          req_ready = 1'b1;
          state_nxt = transfer ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!PRESETn) req_ready = 1'b0;
  end

  assign accept = transfer && req_ready;

  // Registered APB and response outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      PENABLE   <= (state_nxt == ACCESS);
      rsp_valid <= done || dec_err;
      rsp_err   <= dec_err || (done && (tmo || sel_err));
      rsp_rdata <= (done && !PWRITE && !tmo && !sel_err) ? sel_rdata : '0;
      if (accept) begin
        PWRITE <= ~READ_WRITE;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
        PSEL   <= decode(req_addr);
      end else if (done || dec_err) begin
        PSEL   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_nslave.sv
// Bench for apb_master_nslave: directed scenarios plus randomized transfers against a transaction-level model.
module tb_apb_master_nslave;

  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        transfer = 1'b0, READ_WRITE = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [1:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [8:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [15:0] PRDATA = '0;
  logic [1:0]  PREADY = '0, PSLVERR = '0;

  logic        transfer3 = 1'b0;
  logic        req_ready3, rsp_valid3, rsp_err3, penable3, pwrite3;
  logic [7:0]  rsp_rdata3, pwdata3;
  logic [2:0]  psel3;
  logic [8:0]  paddr3;
  logic [23:0] prdata3 = '0;
  logic [2:0]  pready3 = 3'b111, pslverr3 = 3'b000;

  int checks = 0;
  int errors = 0;

  apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT_CYC(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT_CYC(TMO)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer3), .READ_WRITE(READ_WRITE),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite3), .PADDR(paddr3), .PWDATA(pwdata3),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer on the two-completer instance. Expectations come from the transaction:
  // completer = addr[8], one SETUP cycle, waits+1 ACCESS cycles, response 3+waits cycles after accept.
  task automatic xfer(input bit rd, input logic [8:0] a, input logic [7:0] d,
                      input int waits, input bit serr, input logic [7:0] rdat);
    int         slv, acc, setup, lat;
    logic [1:0] exp_sel;
    bit         seen, stable, last;
    slv     = int'(a[8]);
    exp_sel = 2'b01 << slv;
    acc = 0; setup = 0; lat = 0; seen = 0; stable = 1;
    transfer = 1'b1; READ_WRITE = rd; req_addr = a; req_wdata = d;
    #1 chk("idle_req_ready", req_ready, 1);
    @(negedge PCLK);
    transfer = 1'b0; READ_WRITE = 1'($urandom); req_addr = 9'($urandom); req_wdata = 8'($urandom);
    while (!seen && lat < 20) begin
      lat++;
      PRDATA = 16'($urandom); PREADY = 2'($urandom); PSLVERR = 2'($urandom);
      if (rsp_valid) begin
        seen = 1;
      end else if (PSEL != 2'b00) begin
        stable = stable && (PSEL == exp_sel) && (PADDR == a) && (PWRITE == !rd) && (PWDATA == d);
        if (!PENABLE) begin
          setup++;
        end else begin
          acc++;
          last = (acc == waits + 1);
          PREADY[slv]  = last;
          PSLVERR[slv] = last ? serr : 1'($urandom);
          PRDATA[slv*8 +: 8] = last ? rdat : 8'($urandom);
          #1 chk("access_req_ready", req_ready, last);
        end
      end
      if (!seen) @(negedge PCLK);
    end
    chk("rsp_seen", seen, 1);
    chk("latency", lat, 3 + waits);
    chk("setup_cycles", setup, 1);
    chk("access_cycles", acc, waits + 1);
    chk("apb_stable", stable, 1);
    chk("rsp_err", rsp_err, serr);
    chk("rsp_rdata", rsp_rdata, (rd && !serr) ? rdat : 8'h00);
    chk("psel_after", PSEL, 0);
    chk("penable_after", PENABLE, 0);
    @(negedge PCLK);
    PREADY = '0; PSLVERR = '0;
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    int  n;
    bit  quiet;
    #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready3", req_ready3, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("release_req_ready", req_ready, 1);

    // Three completers: index 3 is a decode error, index 2 is valid.
    transfer3 = 1'b1; READ_WRITE = 1'b1; req_addr = 9'h1C0;
    #1 chk("dec_req_ready", req_ready3, 1);
    @(negedge PCLK);
    transfer3 = 1'b0;
    chk("dec_psel", psel3, 0);
    chk("dec_penable", penable3, 0);
    @(negedge PCLK);
    chk("dec_rsp_valid", rsp_valid3, 1);
    chk("dec_rsp_err", rsp_err3, 1);
    chk("dec_rsp_rdata", rsp_rdata3, 0);
    chk("dec_no_penable", penable3, 0);
    @(negedge PCLK);
    chk("dec_pulse", rsp_valid3, 0);
    chk("dec_idle", req_ready3, 1);
    transfer3 = 1'b1; READ_WRITE = 1'b0; req_addr = 9'h100;
    @(negedge PCLK);
    transfer3 = 1'b0;
    chk("s2_psel", psel3, 3'b100);
    @(negedge PCLK);
    chk("s2_penable", penable3, 1);
    @(negedge PCLK);
    chk("s2_rsp_valid", rsp_valid3, 1);
    chk("s2_rsp_err", rsp_err3, 0);

    xfer(1'b0, 9'h0A5, 8'h3C, 0, 1'b0, 8'h00);
    xfer(1'b1, 9'h1F0, 8'h00, 3, 1'b0, 8'h5A);
    xfer(1'b0, 9'h033, 8'h44, 1, 1'b1, 8'h00);
    xfer(1'b1, 9'h120, 8'h00, 0, 1'b1, 8'hAB);

    // Back-to-back: transfer held through the completing ACCESS cycle.
    transfer = 1'b1; READ_WRITE = 1'b0; req_addr = 9'h010; req_wdata = 8'h11;
    @(negedge PCLK);
    READ_WRITE = 1'b1; req_addr = 9'h110; PREADY = 2'b01; PSLVERR = 2'b00;
    chk("b2b_setup_psel", PSEL, 2'b01);
    chk("b2b_setup_penable", PENABLE, 0);
    @(negedge PCLK);
    chk("b2b_access_penable", PENABLE, 1);
    #1 chk("b2b_req_ready", req_ready, 1);
    @(negedge PCLK);
    transfer = 1'b0; PREADY = 2'b10; PRDATA = 16'h7700;
    chk("b2b_wr_rsp", rsp_valid, 1);
    chk("b2b_wr_err", rsp_err, 0);
    chk("b2b_psel2", PSEL, 2'b10);
    chk("b2b_penable_drop", PENABLE, 0);
    chk("b2b_paddr2", PADDR, 9'h110);
    chk("b2b_pwrite2", PWRITE, 0);
    @(negedge PCLK);
    chk("b2b_access2", PENABLE, 1);
    chk("b2b_no_rsp", rsp_valid, 0);
    @(negedge PCLK);
    PREADY = 2'b00;
    chk("b2b_rd_rsp", rsp_valid, 1);
    chk("b2b_rd_data", rsp_rdata, 8'h77);
    chk("b2b_psel_idle", PSEL, 0);
    @(negedge PCLK);
    chk("b2b_pulse", rsp_valid, 0);

    for (int t = 0; t < 24; t++) begin
      xfer(1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), 8'($urandom));
    end

`ifdef APB_TIMEOUT_EN
    transfer = 1'b1; READ_WRITE = 1'b1; req_addr = 9'h1AA; PREADY = 2'b00; PSLVERR = 2'b00;
    @(negedge PCLK);
    transfer = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && !rsp_valid; k++) begin
      @(negedge PCLK);
      if (PENABLE) n++;
    end
    chk("tmo_access_cycles", n, TMO);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    chk("tmo_psel", PSEL, 0);
    chk("tmo_penable", PENABLE, 0);
    @(negedge PCLK);
`endif

    // Reset asserted in the middle of an ACCESS phase.
    transfer = 1'b1; READ_WRITE = 1'b0; req_addr = 9'h1F0; req_wdata = 8'h5A; PREADY = 2'b00;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    chk("mid_in_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_psel", PSEL, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_pwrite", PWRITE, 0);
    chk("mid_paddr", PADDR, 0);
    chk("mid_pwdata", PWDATA, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    PRESETn = 1'b1; PREADY = 2'b11;
    #1 chk("mid_release_ready", req_ready, 1);
    quiet = 1;
    repeat (3) begin
      @(negedge PCLK);
      quiet = quiet && !rsp_valid && (PSEL == 2'b00);
    end
    chk("mid_no_rsp", quiet, 1);
    PREADY = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_nslave.md
APB_MASTER_NSLAVE -- requirements
Module: apb_master_nslave

Interface
REQ-001 Parameter ADDR_W, 9, PADDR/request address width (4..32).
REQ-002 Parameter DATA_W, 8, PWDATA/PRDATA/request data width (8, 16 or 32).
REQ-003 Parameter NUM_SLV, 2, number of APB completers (2..8); SEL_W=clog2(NUM_SLV).
REQ-004 Parameter TIMEOUT_CYC, 16, maximum wait-state cycles before abort (1..255); used only with APB_TIMEOUT_EN.
REQ-005 PCLK  in  1  single clock; all logic on rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-007 transfer  in  1  request valid.
REQ-008 READ_WRITE  in  1  1=read, 0=write.
REQ-009 req_addr  in  ADDR_W  request address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_ready  out  1  request accepted this cycle when transfer=1.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data (0 for writes and errors).
REQ-014 rsp_err  out  1  error qualifier of rsp_valid.
REQ-015 PSEL  out  NUM_SLV  one-hot completer select.
REQ-016 PENABLE, PWRITE  out  1 each  APB access phase / direction.
REQ-017 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address/data.
REQ-018 PRDATA  in  NUM_SLV*DATA_W  packed read data, slice i from completer i.
REQ-019 PREADY, PSLVERR  in  NUM_SLV each  per-completer ready/error.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-021 req_ready SHALL be 1 in IDLE, and in ACCESS during the cycle the selected PREADY=1 (or timeout fires); 0 otherwise.
REQ-022 Accept (transfer&req_ready) latches READ_WRITE, req_addr, req_wdata into PWRITE=~READ_WRITE, PADDR, PWDATA; next state SETUP.
REQ-023 Slave index = PADDR[ADDR_W-1 -: SEL_W]; in SETUP and ACCESS PSEL[index]=1, other bits 0.
REQ-024 Index >= NUM_SLV is a decode error: PSEL stays 0, SETUP->IDLE, no ACCESS, rsp_valid=1 with rsp_err=1 next cycle.
REQ-025 SETUP lasts exactly one cycle, PENABLE=0; then ACCESS with PENABLE=1, PADDR/PWRITE/PWDATA/PSEL held stable.
REQ-026 ACCESS completes on first cycle with PREADY[index]=1; rsp_valid pulses next cycle, rsp_err=PSLVERR[index], rsp_rdata=PRDATA slice (reads only).
REQ-027 PSLVERR sampled only in completing ACCESS cycle; ignored elsewhere.
REQ-028 On completion with transfer=1, new request accepted same cycle; next state SETUP directly (no IDLE), PENABLE drops to 0.
REQ-029 On completion with transfer=0, next state IDLE; PSEL, PENABLE to 0.
REQ-030 Minimum latency accept->rsp_valid = 3 cycles (SETUP, ACCESS, response).
REQ-031 PREADY/PRDATA of unselected completers SHALL not affect any output.

Reset
REQ-032 PRESETn=0 forces IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while asserted.
REQ-033 Reset mid-transfer aborts without rsp_valid; first cycle after release is IDLE with req_ready=1.

Configuration
REQ-034 Macro APB_TIMEOUT_EN defined: wait counter clears on entering ACCESS, increments each ACCESS cycle with PREADY[index]=0; reaching TIMEOUT_CYC forces completion with rsp_err=1, rsp_rdata=0, PSEL/PENABLE deasserted next cycle.
REQ-035 APB_TIMEOUT_EN undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-036 Write addr 0x0A5 data 0x3C, PREADY[0]=1 immediate -> PSEL=01 SETUP one cycle, PENABLE next, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-037 Read addr 0x1F0, PRDATA slice1=0x5A, PREADY[1] after 3 wait cycles -> PSEL=10, PADDR stable 4 ACCESS cycles, rsp_rdata=0x5A.
REQ-038 Back-to-back write 0x010 then read 0x110 with transfer held -> ACCESS->SETUP with no IDLE, PSEL 01->10.
REQ-039 NUM_SLV=3, ADDR_W=9, addr 0x1C0 (index 3) -> PSEL=000, no PENABLE, rsp_err=1.
REQ-040 PSLVERR[0]=1 with PREADY -> rsp_err=1; APB_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY stuck 0 -> abort after 4 wait cycles, rsp_err=1.
REQ-041 PRESETn low during ACCESS -> all outputs 0 asynchronously, no rsp_valid after release.
